axi_slave_rd_responder: RTL

- AXI4 read-channel responder (slave side); complements the team's master-side AXI VIP.
- Accepts one AR request at a time.
- Generates FIXED, INCR and WRAP beat addresses and returns R beats from an internal word memory.
- The memory is preloaded through a backdoor port.
- Used as the target in AXI master bring-up benches and as the reference slave in the UVC environment.

---
 rtl/axi_slave_rd_responder_pkg.sv | 68 ++++++
 rtl/axi_slave_rd_responder_if.sv | 36 +++
 rtl/axi_burst_addr_gen.sv | 92 +++++++++
 rtl/axi_slave_rd_responder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/axi_slave_rd_responder_pkg.sv
// axi_common: shared AXI4 types and the burst address step function used by
// both the read and write responders.
//   brust_size_t / brust_type_t / lock_t / resp_t : AXI field encodings
//   WDATA_SIZE   : bus width in bytes
//   MAX_ARLEN    : largest AxLEN value (beats minus one)
//   axi_next_addr: address of the beat following 'addr' in a burst
package axi_common;

  localparam int unsigned WDATA_SIZE     = 4;
  localparam int unsigned MAX_ARLEN      = 255;
  localparam int unsigned AXI_ADDR_MAX_W = 64;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } brust_size_t;

  typedef enum logic [1:0] {
    FIXED       = 2'd0,
    INCR        = 2'd1,
    WRAP        = 2'd2,
    RSVD_BRUSTT = 2'd3
  } brust_type_t;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    EXCLUSIVE = 2'd1,
    LOCKED    = 2'd2,
    RSVD_LOCK = 2'd3
  } lock_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  // Computed at 64 bits; callers truncate to their address width, which
  // gives modulo-2^ADDR_W wrap for INCR and a consistent WRAP boundary.
  function automatic logic [AXI_ADDR_MAX_W-1:0] axi_next_addr(
    input logic [AXI_ADDR_MAX_W-1:0] addr,
    input brust_size_t               size,
    input logic [7:0]                len,
    input brust_type_t               burst
  );
    logic [AXI_ADDR_MAX_W-1:0] step;
    logic [AXI_ADDR_MAX_W-1:0] container;
    logic [AXI_ADDR_MAX_W-1:0] lower;
    logic [AXI_ADDR_MAX_W-1:0] incr;
    step      = AXI_ADDR_MAX_W'(1) << size;
    container = (AXI_ADDR_MAX_W'(len) + AXI_ADDR_MAX_W'(1)) << size;
    lower     = addr & ~(container - AXI_ADDR_MAX_W'(1));
    incr      = addr + step;
    case (burst)
      INCR:    return incr;
      WRAP:    return (incr == lower + container) ? lower : incr;
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_slave_rd_responder_if.sv
// AXI4 read address + read data channels.
//   master modport: drives AR payload/valid and rready
//   slave modport : drives arready and the R payload/valid
interface axi_slave_rd_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  import axi_common::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  brust_size_t       arsize;
  brust_type_t       arburst;
  lock_t             arlock;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  resp_t             rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Burst address / beat counter with per-beat response classification.
//   clk, rst_n        : clock, synchronous active-low reset
//   load, ld_*        : start a new burst with these parameters
//   adv               : current beat accepted, step to the next one
//   nxt_addr_c        : address of the beat presented after this edge
//   nxt_resp_c        : response for that beat (DECERR > SLVERR > OKAY)
//   nxt_last_c        : that beat is the final one of the burst
module axi_burst_addr_gen
  import axi_common::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
  parameter int unsigned       MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_len,
  input  brust_size_t       ld_size,
  input  brust_type_t       ld_burst,
  input  logic              adv,
  output logic [ADDR_W-1:0] nxt_addr_c,
  output resp_t             nxt_resp_c,
  output logic              nxt_last_c
);

  localparam int unsigned LANE_SHIFT = $clog2(WDATA_SIZE);

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, nxt_len, cnt_q, nxt_cnt;
  brust_size_t       size_q, nxt_size;
  brust_type_t       burst_q, nxt_burst;

  // Bursts the slave cannot serve: reserved type, beats wider than the bus,
  // or a WRAP length that is not 2/4/8/16 beats.
  function automatic logic burst_bad(input logic [7:0] len, input brust_size_t size,
                                     input brust_type_t burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == RSVD_BRUSTT) || (size > SIZE_4B) || (burst == WRAP && !wrap_len_ok);
  endfunction

  function automatic resp_t classify(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                     input brust_size_t size, input brust_type_t burst);
    logic [ADDR_W-1:0] off;
    off = a - MEM_BASE;
    if (a < MEM_BASE || (off >> LANE_SHIFT) >= ADDR_W'(MEM_DEPTH)) return DECERR;
    if (burst_bad(len, size, burst))                             return SLVERR;
    return OKAY;
  endfunction

  // Next-beat selection; erroneous bursts keep their address (behave as FIXED).
  always_comb begin
    nxt_addr_c = addr_q;
    nxt_len    = len_q;
    nxt_size   = size_q;
    nxt_burst  = burst_q;
    nxt_cnt    = cnt_q;
    if (load) begin
      nxt_addr_c = ld_addr;
      nxt_len    = ld_len;
      nxt_size   = ld_size;
      nxt_burst  = ld_burst;
      nxt_cnt    = 8'd0;
    end else if (adv) begin
      nxt_cnt = cnt_q + 8'd1;
      if (!burst_bad(len_q, size_q, burst_q)) begin
        nxt_addr_c = ADDR_W'(axi_next_addr(AXI_ADDR_MAX_W'(addr_q), size_q, len_q, burst_q));
      end
    end
    nxt_resp_c = classify(nxt_addr_c, nxt_len, nxt_size, nxt_burst);
    nxt_last_c = (nxt_cnt == nxt_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= SIZE_1B;
      burst_q <= FIXED;
      cnt_q   <= 8'd0;
    end else begin
      addr_q  <= nxt_addr_c;
      len_q   <= nxt_len;
      size_q  <= nxt_size;
      burst_q <= nxt_burst;
      cnt_q   <= nxt_cnt;
    end
  end

endmodule

// File: rtl/axi_slave_rd_responder.sv
// AXI4 read responder: one AR at a time, R beats from a backdoor-loaded
// word memory. Optional macro AXI_RD_B2B_EN accepts the next AR on the
// last-beat handshake so bursts run with no idle cycle between them.
//   aclk, aresetn           : clock, synchronous active-low reset
//   axi (slave modport)     : AR and R channels
//   bd_we, bd_idx, bd_wdata : backdoor memory write port
module axi_slave_rd_responder
  import axi_common::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_slave_rd_responder_if.slave      axi,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_idx,
  input  logic [DATA_W-1:0]            bd_wdata
);

  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam int unsigned LANE_SHIFT = $clog2(WDATA_SIZE);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic              arready_q, arready_d, arready_c;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mem_word_c;
  resp_t             rresp_q, rresp_d;
  logic              ar_hs_c, r_hs_c, load_beat_c;
  logic [ADDR_W-1:0] nxt_addr_c;
  resp_t             nxt_resp_c;
  logic              nxt_last_c;
  logic              unused_lock_c;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Lock type is not modelled; every access is answered as NORMAL.
  assign unused_lock_c = ^(2'(axi.arlock));

`ifdef AXI_RD_B2B_EN
  // Open the AR channel during the final beat handshake for zero-gap bursts.
  assign arready_c = arready_q || (state_q == BURST && rlast_q && axi.rready);
`else
  assign arready_c = arready_q;
`endif

  assign ar_hs_c = axi.arvalid && arready_c;
  assign r_hs_c  = rvalid_q && axi.rready;

  axi_burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .MEM_BASE (MEM_BASE),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_addr_gen (
    .clk       (aclk),
    .rst_n     (aresetn),
    .load      (ar_hs_c),
    .ld_addr   (axi.araddr),
    .ld_len    (axi.arlen),
    .ld_size   (axi.arsize),
    .ld_burst  (axi.arburst),
    .adv       (r_hs_c),
    .nxt_addr_c(nxt_addr_c),
    .nxt_resp_c(nxt_resp_c),
    .nxt_last_c(nxt_last_c)
  );

  // Backdoor write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (bd_we) mem[bd_idx] <= bd_wdata;
  end

  assign mem_word_c = mem[IDX_W'((nxt_addr_c - MEM_BASE) >> LANE_SHIFT)];

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    load_beat_c = 1'b0;
    case (state_q)
      IDLE:    if (ar_hs_c) state_d = BURST;
      BURST:   if (r_hs_c && rlast_q) state_d = ar_hs_c ? BURST : IDLE;
      default: state_d = IDLE;
    endcase
    if (ar_hs_c) rid_d = axi.arid;
    load_beat_c = (ar_hs_c || r_hs_c) && (state_d == BURST);
    if (load_beat_c) begin
      rresp_d = nxt_resp_c;
      rdata_d = (nxt_resp_c == OKAY) ? mem_word_c : '0;
    end
    arready_d = (state_d == IDLE);
    rvalid_d  = (state_d == BURST);
    rlast_d   = (state_d == BURST) && nxt_last_c;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign axi.arready = arready_c;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

endmodule
